// File: rtl/dbg_port_arbiter_if.sv
// Handshake bundle between the two debug requesters, the arbiter
// and the downstream debug register port.
interface dbg_port_arbiter_if;
  logic        m0_req;
  logic [1:0]  m0_addr;
  logic [31:0] m0_wr_data;
  logic        m0_wr_en;
  logic        m0_ack;
  logic [31:0] m0_rd_data;
  logic        m0_err;

  logic        m1_req;
  logic [1:0]  m1_addr;
  logic [31:0] m1_wr_data;
  logic        m1_wr_en;
  logic        m1_ack;
  logic [31:0] m1_rd_data;
  logic        m1_err;

  logic [1:0]  dbg_addr;
  logic [31:0] dbg_din;
  logic        dbg_wr_en;
  logic        dbg_req;
  logic [31:0] dbg_dout;
  logic        dbg_ack;

  modport slave (
    input  m0_req, m0_addr, m0_wr_data, m0_wr_en,
    output m0_ack, m0_rd_data, m0_err,
    input  m1_req, m1_addr, m1_wr_data, m1_wr_en,
    output m1_ack, m1_rd_data, m1_err,
    output dbg_addr, dbg_din, dbg_wr_en, dbg_req,
    input  dbg_dout, dbg_ack
  );

  modport master (
    output m0_req, m0_addr, m0_wr_data, m0_wr_en,
    input  m0_ack, m0_rd_data, m0_err,
    output m1_req, m1_addr, m1_wr_data, m1_wr_en,
    input  m1_ack, m1_rd_data, m1_err,
    input  dbg_addr, dbg_din, dbg_wr_en, dbg_req,
    output dbg_dout, dbg_ack
  );
endinterface

// File: rtl/dbg_port_arbiter.sv
// Two-requester round-robin arbiter for a single debug register port,
// with a saturating BUSY timeout that completes the request with an error.
module dbg_port_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic               clk,
  input  logic               rst,
  dbg_port_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [15:0] TO_LAST =
    TO_EN ? 16'(TIMEOUT_CYCLES - 1) : 16'h0;

  state_t      state;
  logic        grant;
  logic        last_grant;
  logic [15:0] cnt;
  logic        pick;
  logic        any_req;

  assign any_req = bus.m0_req | bus.m1_req;

  // On contention the requester not served last wins.
  always_comb begin
    pick = bus.m1_req;
    if (bus.m0_req && bus.m1_req)
      pick = ~last_grant;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      grant          <= 1'b0;
      last_grant     <= 1'b1;
      cnt            <= 16'h0;
      bus.dbg_req    <= 1'b0;
      bus.dbg_addr   <= 2'h0;
      bus.dbg_din    <= 32'h0;
      bus.dbg_wr_en  <= 1'b0;
      bus.m0_ack     <= 1'b0;
      bus.m0_err     <= 1'b0;
      bus.m0_rd_data <= 32'h0;
      bus.m1_ack     <= 1'b0;
      bus.m1_err     <= 1'b0;
      bus.m1_rd_data <= 32'h0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any_req) begin
            grant         <= pick;
            bus.dbg_addr  <= pick ? bus.m1_addr : bus.m0_addr;
            bus.dbg_din   <= pick ? bus.m1_wr_data : bus.m0_wr_data;
            bus.dbg_wr_en <= pick ? bus.m1_wr_en : bus.m0_wr_en;
            bus.dbg_req   <= 1'b1;
            cnt           <= 16'h0;
            state         <= BUSY;
          end
        end
        BUSY: begin
          if (bus.dbg_ack) begin
            bus.dbg_req <= 1'b0;
            if (grant) begin
              bus.m1_ack <= 1'b1;
              bus.m1_err <= 1'b0;
              if (!bus.dbg_wr_en)
                bus.m1_rd_data <= bus.dbg_dout;
            end else begin
              bus.m0_ack <= 1'b1;
              bus.m0_err <= 1'b0;
              if (!bus.dbg_wr_en)
                bus.m0_rd_data <= bus.dbg_dout;
            end
            state <= RESP;
          end else if (TO_EN && cnt == TO_LAST) begin
            bus.dbg_req <= 1'b0;
            if (grant) begin
              bus.m1_ack     <= 1'b1;
              bus.m1_err     <= 1'b1;
              bus.m1_rd_data <= 32'h0;
            end else begin
              bus.m0_ack     <= 1'b1;
              bus.m0_err     <= 1'b1;
              bus.m0_rd_data <= 32'h0;
            end
            state <= RESP;
          end else if (cnt != 16'hFFFF) begin
            cnt <= cnt + 16'h1;
          end
        end
        RESP: begin
          bus.m0_ack <= 1'b0;
          bus.m0_err <= 1'b0;
          bus.m1_ack <= 1'b0;
          bus.m1_err <= 1'b0;
          last_grant <= grant;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/dbg_port_arbiter.md
DBG_PORT_ARBITER -- requirements
Module: dbg_port_arbiter

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, default 1024, max cycles BUSY waits for dbg_ack; 0 disables timeout.
REQ-002 SHALL have port: clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports, per requester n in {0,1}: mn_req  input  1  request, held high until mn_ack.
REQ-005 SHALL have ports: mn_addr  input  2  debug register address; mn_wr_data  input  32  write data; mn_wr_en  input  1  write (1) / read (0).
REQ-006 SHALL have ports: mn_ack  output  1  one-cycle completion pulse; mn_rd_data  output  32  read data; mn_err  output  1  timeout flag, valid with mn_ack.
REQ-007 SHALL have downstream ports: dbg_addr  output  2; dbg_din  output  32; dbg_wr_en  output  1; dbg_req  output  1; dbg_dout  input  32; dbg_ack  input  1 (one-cycle pulse).

Function
REQ-008 SHALL implement FSM states IDLE, BUSY, RESP; reset state IDLE.
REQ-009 IDLE: any mn_req high -> grant per round-robin, register mn_addr/mn_wr_data/mn_wr_en onto dbg_addr/dbg_din/dbg_wr_en, set dbg_req=1, clear timeout counter, go BUSY.
REQ-010 Round-robin: single requester granted directly; both high -> requester not granted last; last_grant resets to 1 (m0 wins first contention).
REQ-011 dbg_addr/dbg_din/dbg_wr_en SHALL stay stable while dbg_req high; requester inputs ignored outside IDLE.
REQ-012 BUSY: dbg_ack high -> capture dbg_dout into granted mn_rd_data (reads only; writes leave mn_rd_data unchanged), err=0, dbg_req=0 next cycle, go RESP.
REQ-013 BUSY without ack: counter increments each cycle; on reaching TIMEOUT_CYCLES-1 (TIMEOUT_CYCLES!=0) -> dbg_req=0, granted mn_rd_data=32'h0, err=1, go RESP.
REQ-014 dbg_ack in same cycle as timeout expiry: ack wins, err=0, data captured.
REQ-015 RESP: granted mn_ack=1 for exactly one cycle with mn_err valid, update last_grant, go IDLE; ungranted mn_ack stays 0.
REQ-016 Requester SHALL drop mn_req on edge where mn_ack sampled; arbiter re-samples requests only in IDLE (no back-to-back grant in RESP).
REQ-017 Latency: req sampled IDLE cycle N -> dbg_req high N+1; dbg_ack at cycle M -> mn_ack high M+1, IDLE M+2; minimum req-to-ack 3 cycles.
REQ-018 dbg_ack outside BUSY SHALL be ignored (no state, data or ack change).
REQ-019 Timeout counter 16 bits, saturating; TIMEOUT_CYCLES SHALL be <= 65535.
REQ-020 mn_err SHALL be 0 whenever mn_ack is 0.

Reset
REQ-021 rst SHALL immediately force: state IDLE, dbg_req=0, dbg_addr=0, dbg_din=0, dbg_wr_en=0, all mn_ack=0, mn_err=0, mn_rd_data=32'h0, counter=0, last_grant=1.
REQ-022 rst mid-transaction SHALL abandon it with no mn_ack; late dbg_ack after reset ignored per REQ-018.

Verification
REQ-023 m0 read addr 2, dbg_ack 2 cycles after dbg_req, dbg_dout=32'hCAFE0001 -> m0_ack one cycle, m0_rd_data=32'hCAFE0001, m0_err=0, m1_ack=0.
REQ-024 m0 and m1 req same cycle after reset -> m0 granted first, m1 granted next IDLE; repeated contention alternates m0,m1,m0.
REQ-025 m1 write addr 1 data 32'h12345678, no dbg_ack, TIMEOUT_CYCLES=8 -> dbg_req drops after 8 BUSY cycles, m1_ack with m1_err=1, m1_rd_data=0.
REQ-026 dbg_ack on exact timeout cycle -> m_err=0, data captured; stray dbg_ack in IDLE -> no mn_ack, state IDLE.
REQ-027 rst asserted while BUSY, then dbg_ack -> dbg_req=0 immediately, no mn_ack, all outputs at reset values.
REQ-028 m1 changes m1_addr/m1_wr_data while BUSY -> dbg_addr/dbg_din unchanged until transaction complete.
